rename_regfile: RTL
===================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter TAG_W, default 5, rename-tag width.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of commit write ports.
REQ-005 SHALL have port clk  in  1  clock, all state updated on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  in  1  clear all busy bits and invalidate checkpoint.
REQ-008 SHALL have port wr_en  in  NWR  per-port commit valid.
REQ-009 SHALL have port wr_id  in  NWR*5  per-port destination register.
REQ-010 SHALL have port wr_tag  in  NWR*TAG_W  per-port producer tag.
REQ-011 SHALL have port wr_val  in  NWR*XLEN  per-port result value.
REQ-012 SHALL have port ren_en  in  1  rename valid: mark ren_reg busy on ren_tag.
REQ-013 SHALL have port ren_reg  in  5  renamed register; ren_tag  in  TAG_W  new producer tag.
REQ-014 SHALL have port rd_id  in  NRD*5  per-port read register.
REQ-015 SHALL have port rd_busy  out  NRD, rd_tag  out  NRD*TAG_W, rd_val  out  NRD*XLEN  per-port read results, combinational.
REQ-016 SHALL have port ckpt_save  in  1, ckpt_restore  in  1  checkpoint commands; ckpt_valid  out  1  checkpoint held.

Function
REQ-017 SHALL hold 32 entries {value XLEN, busy 1, tag TAG_W}; x0 SHALL read value 0, busy 0, and ignore all writes/renames.
REQ-018 SHALL update value on every wr_en port with wr_id!=0; busy SHALL clear only if entry busy and wr_tag equals stored tag; stale tag leaves busy/tag unchanged.
REQ-019 SHALL, when two write ports target the same register, take value from the higher-index port; busy clears if either port's tag matches.
REQ-020 SHALL, on ren_en with ren_reg!=0, set busy=1 and tag=ren_tag next cycle; rename SHALL win over a same-cycle commit's busy-clear on that register, commit value still written.
REQ-021 SHALL maintain one checkpoint copy of all busy/tag bits; ckpt_save (ckpt_restore low) SHALL capture the post-update busy/tag state of this cycle and set ckpt_valid=1 next cycle.
REQ-022 SHALL apply commit busy-clear rule (REQ-018) to the checkpoint copy every cycle while ckpt_valid=1, using checkpoint tags.
REQ-023 SHALL, on ckpt_restore with ckpt_valid=1, load busy/tag from checkpoint (after this cycle's commit clears), clear ckpt_valid, ignore same-cycle ren_en and ckpt_save; values are never restored.
REQ-024 SHALL ignore ckpt_restore when ckpt_valid=0; ckpt_save while ckpt_valid=1 SHALL overwrite the checkpoint.
REQ-025 SHALL, on flush, clear all busy bits and ckpt_valid, keep values and tags, still apply same-cycle commit values, and ignore ren_en, ckpt_save, ckpt_restore.
REQ-026 SHALL apply priority rst > flush > ckpt_restore > normal update.
REQ-027 SHALL have read latency zero: rd_* reflect stored state combinationally, modified only per REQ-031.

Reset
REQ-028 SHALL, on rst, clear all values, busy bits, tags, checkpoint bits and ckpt_valid to 0 on the next edge.
REQ-029 SHALL, during rst, hold rd_busy=0, rd_tag=0, rd_val=0 from the cycle after rst is first sampled.
REQ-030 SHALL discard any in-flight checkpoint and pending commit when rst asserts mid-operation.

Configuration
REQ-031 SHALL, with macro RENAME_REGFILE_BYPASS_EN defined, forward same-cycle events to reads: matching commit (busy, tag equal) gives rd_val=wr_val, rd_busy=0; rename of rd_id gives rd_busy=1, rd_tag=ren_tag (rename wins); without macro, reads show stored state only.

Verification
REQ-032 SHALL cover: ren x5 tag 3, next cycle commit x5 tag 3 val 0xAB -> following cycle rd x5 busy 0 val 0xAB.
REQ-033 SHALL cover: ren x5 tag 3, then ren x5 tag 7, commit x5 tag 3 val 0x11 -> x5 val 0x11, busy 1, tag 7.
REQ-034 SHALL cover: ren x6 tag 2, ckpt_save, ren x6 tag 9, commit tag 2 to x6, ckpt_restore -> x6 busy 0, ckpt_valid 0.
REQ-035 SHALL cover: both ports commit x7 (tags 1,4, vals 0x1,0x4), x7 busy tag 4 -> x7 val 0x4, busy 0.
REQ-036 SHALL cover: with bypass, same-cycle commit x8 tag 5 val 0x55 while x8 busy tag 5 -> rd busy 0 val 0x55 same cycle; without bypass -> busy 1 that cycle.
REQ-037 SHALL cover: flush with ren_en and ckpt_save asserted, x0 write 0xFF -> all busy 0, ckpt_valid 0, x0 reads 0.

Source files
------------

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - 32-entry register file with rename busy/tag tracking and one checkpoint (option: RENAME_REGFILE_BYPASS_EN)
module rename_regfile #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*5-1:0]      wr_id,
    input  logic [NWR*TAG_W-1:0]  wr_tag,
    input  logic [NWR*XLEN-1:0]   wr_val,
    input  logic                  ren_en,
    input  logic [4:0]            ren_reg,
    input  logic [TAG_W-1:0]      ren_tag,
    input  logic [NRD*5-1:0]      rd_id,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    output logic [NRD*XLEN-1:0]   rd_val,
    input  logic                  ckpt_save,
    input  logic                  ckpt_restore,
    output logic                  ckpt_valid
);

    localparam int NREG = 32;

    // Architectural state and its next-state image
    logic [XLEN-1:0]  val_q  [NREG];
    logic [XLEN-1:0]  val_d  [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    // Checkpoint copy of the busy/tag bits (values are never checkpointed)
    logic [TAG_W-1:0] ctag_q [NREG];
    logic [TAG_W-1:0] ctag_d [NREG];
    logic [NREG-1:0]  cbusy_q;
    logic [NREG-1:0]  cbusy_d;
    logic             cvalid_q;
    logic             cvalid_d;

    // Per-port one-hot register decode of commits, and the resulting busy clears
    logic [NREG-1:0]  wr_hit [NWR];
    logic [NREG-1:0]  clr_main;
    logic [NREG-1:0]  clr_ckpt;

    logic             restore_go;
    logic             save_go;
    logic             ren_go;

    // Command qualification: flush overrides restore, restore overrides rename/save
    always_comb begin
        restore_go = ckpt_restore && cvalid_q && !flush;
        save_go    = ckpt_save && !ckpt_restore && !flush;
        ren_go     = ren_en && (ren_reg != 5'd0) && !flush && !restore_go;
    end

    // Decode commit ports to registers; x0 never matches
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            wr_hit[p] = '0;
            for (int r = 1; r < NREG; r++) begin
                wr_hit[p][r] = wr_en[p] && (wr_id[p*5 +: 5] == 5'(r));
            end
        end
    end

    // A commit clears busy only when its tag matches the current producer tag
    always_comb begin
        clr_main = '0;
        clr_ckpt = '0;
        for (int p = 0; p < NWR; p++) begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit[p][r] && busy_q[r] && (tag_q[r] == wr_tag[p*TAG_W +: TAG_W]))
                    clr_main[r] = 1'b1;
                if (wr_hit[p][r] && cbusy_q[r] && (ctag_q[r] == wr_tag[p*TAG_W +: TAG_W]))
                    clr_ckpt[r] = 1'b1;
            end
        end
    end

    // Next-state computation: commits, then flush / restore / rename+save
    always_comb begin
        val_d    = val_q;
        tag_d    = tag_q;
        ctag_d   = ctag_q;
        busy_d   = busy_q & ~clr_main;
        cbusy_d  = cvalid_q ? (cbusy_q & ~clr_ckpt) : cbusy_q;
        cvalid_d = cvalid_q;

        // Later ports overwrite earlier ones so the highest-index port wins
        for (int p = 0; p < NWR; p++) begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit[p][r])
                    val_d[r] = wr_val[p*XLEN +: XLEN];
            end
        end

        if (flush) begin
            busy_d   = '0;
            cvalid_d = 1'b0;
        end else if (restore_go) begin
            busy_d   = cbusy_q & ~clr_ckpt;
            tag_d    = ctag_q;
            cvalid_d = 1'b0;
        end else begin
            if (ren_go) begin
                busy_d[ren_reg] = 1'b1;
                tag_d[ren_reg]  = ren_tag;
            end
            // Save captures the state as it will be after this edge
            if (save_go) begin
                cbusy_d  = busy_d;
                ctag_d   = tag_d;
                cvalid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r]  <= '0;
                tag_q[r]  <= '0;
                ctag_q[r] <= '0;
            end
            busy_q   <= '0;
            cbusy_q  <= '0;
            cvalid_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r]  <= val_d[r];
                tag_q[r]  <= tag_d[r];
                ctag_q[r] <= ctag_d[r];
            end
            busy_q   <= busy_d;
            cbusy_q  <= cbusy_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign ckpt_valid = cvalid_q;

    // Zero-latency read ports, optionally forwarding this cycle's commit/rename
    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        rd_val  = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i]                 = busy_q[rd_id[i*5 +: 5]];
            rd_tag[i*TAG_W +: TAG_W]   = tag_q[rd_id[i*5 +: 5]];
            rd_val[i*XLEN +: XLEN]     = val_q[rd_id[i*5 +: 5]];
`ifdef RENAME_REGFILE_BYPASS_EN
            if (!rst) begin
                if (clr_main[rd_id[i*5 +: 5]]) begin
                    rd_busy[i]             = 1'b0;
                    rd_val[i*XLEN +: XLEN] = val_d[rd_id[i*5 +: 5]];
                end
                if (ren_go && (ren_reg == rd_id[i*5 +: 5])) begin
                    rd_busy[i]               = 1'b1;
                    rd_tag[i*TAG_W +: TAG_W] = ren_tag;
                end
            end
`endif
        end
    end

endmodule
